// File: rtl/dsp_modem_if.sv
// AXI-Stream links between the PS FIFOs and the modem datapath.
// The modem is the slave side; the PS/FIFO side (or a bench) is the master.
interface dsp_modem_if;
    logic [31:0] ps2pl_fifo_m_axis_tdata;
    logic [3:0]  ps2pl_fifo_m_axis_tkeep;
    logic        ps2pl_fifo_m_axis_tlast;
    logic        ps2pl_fifo_m_axis_tvalid;
    logic        ps2pl_fifo_m_axis_tready;
    logic [31:0] pl2ps_fifo_s_axis_tdata;
    logic [3:0]  pl2ps_fifo_s_axis_tkeep;
    logic        pl2ps_fifo_s_axis_tlast;
    logic        pl2ps_fifo_s_axis_tvalid;
    logic        pl2ps_fifo_s_axis_tready;

    modport slave (
        input  ps2pl_fifo_m_axis_tdata,
        input  ps2pl_fifo_m_axis_tkeep,
        input  ps2pl_fifo_m_axis_tlast,
        input  ps2pl_fifo_m_axis_tvalid,
        output ps2pl_fifo_m_axis_tready,
        output pl2ps_fifo_s_axis_tdata,
        output pl2ps_fifo_s_axis_tkeep,
        output pl2ps_fifo_s_axis_tlast,
        output pl2ps_fifo_s_axis_tvalid,
        input  pl2ps_fifo_s_axis_tready
    );

    modport master (
        output ps2pl_fifo_m_axis_tdata,
        output ps2pl_fifo_m_axis_tkeep,
        output ps2pl_fifo_m_axis_tlast,
        output ps2pl_fifo_m_axis_tvalid,
        input  ps2pl_fifo_m_axis_tready,
        input  pl2ps_fifo_s_axis_tdata,
        input  pl2ps_fifo_s_axis_tkeep,
        input  pl2ps_fifo_s_axis_tlast,
        input  pl2ps_fifo_s_axis_tvalid,
        output pl2ps_fifo_s_axis_tready
    );
endinterface

// File: rtl/dsp_modem.sv
// BPSK modem on an fs/4 carrier: TX serialises 32-bit words onto the DAC,
// RX correlates ADC samples per symbol, slices bits and frames words on idle symbols.
module dsp_modem #(
    parameter int ADC_BITS  = 28,
    parameter int DAC_BITS  = 14,
    parameter int SPS       = 16,
    parameter int DAC_AMP   = 8191,
    parameter int LOOP_LAT  = 1,
    parameter int ENERGY_TH = SPS/2*DAC_AMP/4
) (
    input  logic                  adc_dco_clk,
    input  logic                  resetn,
    input  logic                  adc_overrange,
    input  logic [ADC_BITS/2-1:0] adc_data_in,
    output logic                  dac_dco_clk,
    output logic [DAC_BITS-1:0]   dac_data_out,
    dsp_modem_if.slave            axis
);
    localparam int XW    = ADC_BITS/2;
    localparam int CW    = $clog2(SPS);
    localparam int ACC_W = XW + CW + 2;

    localparam logic [CW-1:0] SYM_LAST = CW'(SPS-1);
    localparam logic [CW-1:0] RX_RST   = CW'((SPS - (LOOP_LAT % SPS)) % SPS);

    localparam logic signed [DAC_BITS-1:0] AMP_P = DAC_BITS'(DAC_AMP);
    localparam logic signed [DAC_BITS-1:0] AMP_N = DAC_BITS'(-DAC_AMP);
    localparam logic signed [XW-1:0]       X_MAX = XW'((1 << (XW-1)) - 1);
    localparam logic signed [ACC_W-1:0]    E_TH  = ACC_W'(ENERGY_TH);

    typedef enum logic {IDLE, SEND} tx_state_t;

    // ---------------- TX ----------------
    tx_state_t r_state, w_state_nxt;
    logic [CW-1:0]  r_sym_cnt;
    logic [31:0]    r_tx_sh, w_tx_sh_nxt;
    logic [4:0]     r_tx_bit, w_tx_bit_nxt;
    logic           r_tx_last, w_tx_last_nxt;
    logic           r_tx_gap, w_tx_gap_nxt;
    logic           w_sym_end, w_tx_ready, w_tx_hs;
    logic signed [DAC_BITS-1:0] r_dac, w_dac;
    logic           w_unused;

    assign w_sym_end = (r_sym_cnt == SYM_LAST);
    assign w_tx_hs   = w_tx_ready & axis.ps2pl_fifo_m_axis_tvalid;
    assign w_unused  = ^axis.ps2pl_fifo_m_axis_tkeep;

    // Words are only accepted on a symbol boundary; r_tx_gap forces one
    // silent symbol after a packet so the receiver sees the frame end.
    always_comb begin
        w_tx_ready = 1'b0;
        if (w_sym_end && !r_tx_gap) begin
            case (r_state)
                IDLE:    w_tx_ready = 1'b1;
                SEND:    w_tx_ready = (r_tx_bit == 5'd0) && !r_tx_last;
                default: w_tx_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_sh_nxt   = r_tx_sh;
        w_tx_bit_nxt  = r_tx_bit;
        w_tx_last_nxt = r_tx_last;
        w_tx_gap_nxt  = r_tx_gap;
        if (w_sym_end) begin
            w_tx_gap_nxt = 1'b0;
            if (w_tx_hs) begin
                w_state_nxt   = SEND;
                w_tx_sh_nxt   = axis.ps2pl_fifo_m_axis_tdata;
                w_tx_bit_nxt  = 5'd31;
                w_tx_last_nxt = axis.ps2pl_fifo_m_axis_tlast;
            end else if (r_state == SEND) begin
                if (r_tx_bit == 5'd0) begin
                    w_state_nxt   = IDLE;
                    w_tx_gap_nxt  = r_tx_last;
                    w_tx_last_nxt = 1'b0;
                end else begin
                    w_tx_sh_nxt  = {r_tx_sh[30:0], 1'b0};
                    w_tx_bit_nxt = r_tx_bit - 5'd1;
                end
            end
        end
    end

    // Carrier phase p0:+1 p1:0 p2:-1 p3:0, sign flipped for a 0 bit
    always_comb begin
        w_dac = '0;
        if (r_state == SEND) begin
            case (r_sym_cnt[1:0])
                2'd0:    w_dac = r_tx_sh[31] ? AMP_P : AMP_N;
                2'd2:    w_dac = r_tx_sh[31] ? AMP_N : AMP_P;
                default: w_dac = '0;
            endcase
        end
    end

    always_ff @(posedge adc_dco_clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_sym_cnt <= '0;
            r_tx_sh   <= '0;
            r_tx_bit  <= '0;
            r_tx_last <= 1'b0;
            r_tx_gap  <= 1'b0;
            r_dac     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sym_cnt <= w_sym_end ? '0 : r_sym_cnt + CW'(1);
            r_tx_sh   <= w_tx_sh_nxt;
            r_tx_bit  <= w_tx_bit_nxt;
            r_tx_last <= w_tx_last_nxt;
            r_tx_gap  <= w_tx_gap_nxt;
            r_dac     <= w_dac;
        end
    end

    // ---------------- RX ----------------
    logic [CW-1:0]           r_rx_cnt;
    logic signed [XW-1:0]    w_x;
    logic signed [ACC_W-1:0] r_acc, r_eng, w_acc_nxt, w_eng_nxt, w_xe, w_absx;
    logic [30:0]             r_rx_sh;
    logic [31:0]             r_held, w_rx_word;
    logic [4:0]              r_rx_bit;
    logic                    r_held_vld;
    logic                    w_rx_dec, w_rx_idle, w_rx_bit;
    logic                    w_emit, w_emit_last;
    logic [31:0]             r_out_data;
    logic                    r_out_last, r_out_vld;

    always_comb begin
        w_x = $signed(adc_data_in);
        if (adc_overrange)
            w_x = adc_data_in[XW-1] ? -X_MAX : X_MAX;
        w_xe      = ACC_W'(w_x);
        w_absx    = w_x[XW-1] ? -w_xe : w_xe;
        w_acc_nxt = r_acc;
        w_eng_nxt = r_eng;
        case (r_rx_cnt[1:0])
            2'd0: begin
                w_acc_nxt = r_acc + w_xe;
                w_eng_nxt = r_eng + w_absx;
            end
            2'd2: begin
                w_acc_nxt = r_acc - w_xe;
                w_eng_nxt = r_eng + w_absx;
            end
            default: ;
        endcase
    end

    // The decision uses the sums including the last sample of the window
    assign w_rx_dec  = (r_rx_cnt == SYM_LAST);
    assign w_rx_idle = (w_eng_nxt < E_TH);
    assign w_rx_bit  = ~w_acc_nxt[ACC_W-1];
    assign w_rx_word = {r_rx_sh, w_rx_bit};

    always_comb begin
        w_emit      = 1'b0;
        w_emit_last = 1'b0;
        if (w_rx_dec && r_held_vld) begin
            if (w_rx_idle) begin
                w_emit      = 1'b1;
                w_emit_last = 1'b1;
            end else if (r_rx_bit == 5'd31) begin
                w_emit = 1'b1;
            end
        end
    end

    always_ff @(posedge adc_dco_clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_cnt   <= RX_RST;
            r_acc      <= '0;
            r_eng      <= '0;
            r_rx_sh    <= '0;
            r_rx_bit   <= '0;
            r_held     <= '0;
            r_held_vld <= 1'b0;
        end else begin
            r_rx_cnt <= w_rx_dec ? '0 : r_rx_cnt + CW'(1);
            if (w_rx_dec) begin
                r_acc <= '0;
                r_eng <= '0;
                if (w_rx_idle) begin
                    r_rx_bit   <= '0;
                    r_held_vld <= 1'b0;
                end else begin
                    r_rx_sh <= w_rx_word[30:0];
                    if (r_rx_bit == 5'd31) begin
                        r_rx_bit   <= '0;
                        r_held     <= w_rx_word;
                        r_held_vld <= 1'b1;
                    end else begin
                        r_rx_bit <= r_rx_bit + 5'd1;
                    end
                end
            end else begin
                r_acc <= w_acc_nxt;
                r_eng <= w_eng_nxt;
            end
        end
    end

    // Single output slot: a word emitted while the slot is still occupied is dropped
    always_ff @(posedge adc_dco_clk or negedge resetn) begin
        if (!resetn) begin
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_out_vld  <= 1'b0;
        end else begin
            if (axis.pl2ps_fifo_s_axis_tready)
                r_out_vld <= 1'b0;
            if (w_emit && (!r_out_vld || axis.pl2ps_fifo_s_axis_tready)) begin
                r_out_data <= r_held;
                r_out_last <= w_emit_last;
                r_out_vld  <= 1'b1;
            end
        end
    end

    assign dac_dco_clk                   = adc_dco_clk;
    assign dac_data_out                  = r_dac;
    assign axis.ps2pl_fifo_m_axis_tready = w_tx_ready;
    assign axis.pl2ps_fifo_s_axis_tdata  = r_out_data;
    assign axis.pl2ps_fifo_s_axis_tkeep  = 4'hF;
    assign axis.pl2ps_fifo_s_axis_tlast  = r_out_last;
    assign axis.pl2ps_fifo_s_axis_tvalid = r_out_vld;
endmodule

// File: tb/tb_dsp_modem.sv
// Scoreboard bench for dsp_modem: DAC waveform checks plus RX words checked
// against an expected queue by an independent monitor.
module tb_dsp_modem;
    localparam int SPS = 16;
    localparam int AMP = 8191;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ovr;
    logic [13:0] adc;
    logic        dac_clk;
    logic [13:0] dac;
    int          adc_mode = 0;   // 0 loopback, 1 sign-only with overrange, 2 stuck at zero

    dsp_modem_if bus();

    dsp_modem dut (
        .adc_dco_clk  (clk),
        .resetn       (rst_n),
        .adc_overrange(ovr),
        .adc_data_in  (adc),
        .dac_dco_clk  (dac_clk),
        .dac_data_out (dac),
        .axis         (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        adc = dac;
        ovr = 1'b0;
        if (adc_mode == 1) begin
            adc = ($signed(dac) > 0) ? 14'h0001 : (($signed(dac) < 0) ? 14'h3FFF : 14'h0000);
            ovr = (dac != 14'h0);
        end else if (adc_mode == 2) begin
            adc = 14'h0;
        end
    end

    typedef struct packed {logic [31:0] d; logic l;} rxw_t;
    rxw_t exp_q[$];
    rxw_t mon_e;
    int   errors = 0, checks = 0, rx_words = 0, n_pushed = 0;
    int   nz, chg;
    logic [31:0] cap;
    event hs_ev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic l);
        exp_q.push_back('{d: d, l: l});
        n_pushed++;
    endtask

    // Monitor: every accepted RX word is compared against the queue head
    always @(negedge clk) begin
        if (rst_n && bus.pl2ps_fifo_s_axis_tvalid && bus.pl2ps_fifo_s_axis_tready) begin
            rx_words++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got data=%h last=%b, expected no word",
                         bus.pl2ps_fifo_s_axis_tdata, bus.pl2ps_fifo_s_axis_tlast);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.pl2ps_fifo_s_axis_tdata !== mon_e.d || bus.pl2ps_fifo_s_axis_tlast !== mon_e.l ||
                    bus.pl2ps_fifo_s_axis_tkeep !== 4'hF) begin
                    errors++;
                    $display("FAIL rx_word: got data=%h last=%b keep=%h, expected data=%h last=%b keep=f",
                             bus.pl2ps_fifo_s_axis_tdata, bus.pl2ps_fifo_s_axis_tlast,
                             bus.pl2ps_fifo_s_axis_tkeep, mon_e.d, mon_e.l);
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l);
        int n = 0;
        bus.ps2pl_fifo_m_axis_tdata  = d;
        bus.ps2pl_fifo_m_axis_tlast  = l;
        bus.ps2pl_fifo_m_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!bus.ps2pl_fifo_m_axis_tready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_wait", 64'(bus.ps2pl_fifo_m_axis_tready), 64'd1);
        if (bus.ps2pl_fifo_m_axis_tready) @(posedge clk);
        #1;
        bus.ps2pl_fifo_m_axis_tvalid = 1'b0;
        -> hs_ev;
    endtask

    // Expected DAC stream from the handshake: MSB-first bits, 16 samples each
    task automatic check_dac(input logic [31:0] w0, input logic [31:0] w1, input int nw);
        logic [31:0] w;
        logic        b;
        logic [13:0] e;
        @(hs_ev);
        @(negedge clk);
        for (int k = 0; k < nw*512 + SPS; k++) begin
            @(negedge clk);
            e = 14'h0;
            if (k < nw*512) begin
                w = (k < 512) ? w0 : w1;
                b = w[31 - ((k % 512) / SPS)];
                if (k % 4 == 0) e = b ? 14'(AMP) : 14'(-AMP);
                if (k % 4 == 2) e = b ? 14'(-AMP) : 14'(AMP);
            end
            checks++;
            if (dac !== e) begin
                errors++;
                $display("FAIL dac_sample[%0d]: got %0d, expected %0d", k, $signed(dac), $signed(e));
            end
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("rx_drain", 64'(exp_q.size()), 64'd0);
        repeat (40) @(negedge clk);
    endtask

    task automatic wait_tvalid(input string name, input int limit);
        int n = 0;
        while (!bus.pl2ps_fifo_s_axis_tvalid && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(bus.pl2ps_fifo_s_axis_tvalid), 64'd1);
    endtask

    initial begin
        bus.ps2pl_fifo_m_axis_tdata  = '0;
        bus.ps2pl_fifo_m_axis_tkeep  = 4'h0;
        bus.ps2pl_fifo_m_axis_tlast  = 1'b0;
        bus.ps2pl_fifo_m_axis_tvalid = 1'b0;
        bus.pl2ps_fifo_s_axis_tready = 1'b1;

        // Reset state
        repeat (10) @(posedge clk);
        #1;
        chk("rst_dac", 64'(dac), 64'd0);
        chk("rst_rx_tvalid", 64'(bus.pl2ps_fifo_s_axis_tvalid), 64'd0);
        chk("rst_tx_tready", 64'(bus.ps2pl_fifo_m_axis_tready), 64'd0);
        chk("rst_rx_tkeep", 64'(bus.pl2ps_fifo_s_axis_tkeep), 64'hF);
        chk("rst_rx_tdata", 64'(bus.pl2ps_fifo_s_axis_tdata), 64'd0);
        rst_n = 1'b1;
        nz = 0;
        repeat (200) @(negedge clk) if (dac != 14'h0) nz++;
        chk("idle_dac_quiet", 64'(nz), 64'd0);
        chk("idle_no_rx", 64'(rx_words), 64'd0);

        // Single-bit-set word: waveform shape plus loopback
        push_exp(32'h8000_0000, 1'b1);
        fork
            send_word(32'h8000_0000, 1'b1);
            check_dac(32'h8000_0000, 32'h0, 1);
        join
        wait_drain(1500);

        // Loopback of a mixed pattern
        push_exp(32'hA500_0001, 1'b1);
        send_word(32'hA500_0001, 1'b1);
        wait_drain(1500);

        // Back-to-back words, no idle gap on the DAC
        push_exp(32'hDEAD_BEEF, 1'b0);
        push_exp(32'h1234_5678, 1'b1);
        fork
            begin
                send_word(32'hDEAD_BEEF, 1'b0);
                send_word(32'h1234_5678, 1'b1);
            end
            check_dac(32'hDEAD_BEEF, 32'h1234_5678, 2);
        join
        wait_drain(1500);

        // Backpressure: first word held stable, second dropped
        @(posedge clk); #1;
        bus.pl2ps_fifo_s_axis_tready = 1'b0;
        push_exp(32'hCAFE_F00D, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0);
        send_word(32'h0BAD_C0DE, 1'b1);
        wait_tvalid("bp_tvalid_wait", 1500);
        chk("bp_first_data", 64'(bus.pl2ps_fifo_s_axis_tdata), 64'hCAFE_F00D);
        chk("bp_first_last", 64'(bus.pl2ps_fifo_s_axis_tlast), 64'd0);
        cap = bus.pl2ps_fifo_s_axis_tdata;
        chg = 0;
        repeat (600) @(negedge clk)
            if (bus.pl2ps_fifo_s_axis_tdata !== cap || !bus.pl2ps_fifo_s_axis_tvalid) chg++;
        chk("bp_stable", 64'(chg), 64'd0);
        @(posedge clk); #1;
        bus.pl2ps_fifo_s_axis_tready = 1'b1;
        wait_drain(100);
        repeat (200) @(negedge clk);
        chk("bp_second_dropped", 64'(rx_words), 64'(n_pushed));

        // Overrange: +/-1 on the ADC is only decodable if clamped to full scale
        adc_mode = 1;
        push_exp(32'h3C5A_0FF0, 1'b1);
        send_word(32'h3C5A_0FF0, 1'b1);
        wait_drain(1500);
        adc_mode = 0;

        // Stuck-at-zero ADC: nothing received
        adc_mode = 2;
        send_word(32'h1234_5678, 1'b1);
        repeat (800) @(negedge clk);
        chk("zero_adc_no_word", 64'(rx_words), 64'(n_pushed));
        adc_mode = 0;

        // Asynchronous reset mid-word with an RX word pending
        @(posedge clk); #1;
        bus.pl2ps_fifo_s_axis_tready = 1'b0;
        send_word(32'h55AA_33CC, 1'b1);
        wait_tvalid("rst_pending_wait", 1500);
        send_word(32'h0F1E_2D3C, 1'b0);
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dac", 64'(dac), 64'd0);
        chk("arst_rx_tvalid", 64'(bus.pl2ps_fifo_s_axis_tvalid), 64'd0);
        chk("arst_rx_tdata", 64'(bus.pl2ps_fifo_s_axis_tdata), 64'd0);
        chk("arst_rx_tlast", 64'(bus.pl2ps_fifo_s_axis_tlast), 64'd0);
        chk("arst_tx_tready", 64'(bus.ps2pl_fifo_m_axis_tready), 64'd0);
        chk("arst_rx_tkeep", 64'(bus.pl2ps_fifo_s_axis_tkeep), 64'hF);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.pl2ps_fifo_s_axis_tready = 1'b1;
        nz = 0;
        repeat (800) @(negedge clk) if (dac != 14'h0) nz++;
        chk("post_rst_dac_quiet", 64'(nz), 64'd0);
        chk("post_rst_no_rx", 64'(rx_words), 64'(n_pushed));
        chk("post_rst_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
